// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Key map is indexed {row, col}; rows and columns are numbered from the top-left key.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kypd_state_e;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    // Element 0 is row 0 / col 0 (key '1'); element 15 is row 3 / col 3 (key 'D').
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

    // Exactly one row low; zero or several low rows are treated as no key.
    function automatic logic one_row_low(input logic [3:0] rows);
        logic hit;
        case (rows)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Bit 3 of the row bus is row 0.
    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b0111: idx = 2'd0;
            4'b1011: idx = 2'd1;
            4'b1101: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/kypd_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad row inputs.
module kypd_row_sync (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] rows_s
);

    logic [3:0] meta_q;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            meta_q <= 4'b1111;
            rows_s <= 4'b1111;
        end else begin
            meta_q <= row_in;
            rows_s <= meta_q;
        end
    end

endmodule

// File: rtl/hex_keypad_scanner.sv
// Scans a 4x4 hex keypad one column at a time, debounces press and release,
// and shifts each accepted digit into a 16-bit word (newest nibble lowest).
module hex_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned COL_DWELL  = 1000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    input  logic        clear,
    output logic [3:0]  col_out,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] word
);

    localparam int unsigned DWELL_W = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(COL_DWELL - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);

    logic [3:0]         rows_s;

    kypd_state_e        state_q,  state_d;
    logic [1:0]         col_idx_q, col_idx_d;
    logic [DWELL_W-1:0] dwell_q,  dwell_d;
    logic [DEB_W-1:0]   deb_q,    deb_d;
    logic [3:0]         pat_q,    pat_d;
    logic [3:0]         col_out_d;
    logic               key_valid_d;
    logic [3:0]         key_code_d;
    logic [15:0]        word_d;
    logic [3:0]         key_new;

    kypd_row_sync u_row_sync (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .row_in (row_in),
        .rows_s (rows_s)
    );

    // Decoded value of the latched key; only meaningful in DEBOUNCE.
    assign key_new = KEY_MAP[{row_index(pat_q), col_idx_q}];

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            dwell_q   <= '0;
            deb_q     <= '0;
            pat_q     <= 4'b1111;
            col_out   <= 4'b0111;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            word      <= 16'h0000;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            dwell_q   <= dwell_d;
            deb_q     <= deb_d;
            pat_q     <= pat_d;
            col_out   <= col_out_d;
            key_valid <= key_valid_d;
            key_code  <= key_code_d;
            word      <= word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        pat_d       = pat_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code;
        word_d      = word;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (one_row_low(rows_s)) begin
                        pat_d   = rows_s;
                        deb_d   = DEB_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end

            DEBOUNCE: begin
                if (rows_s == pat_q) begin
                    if (deb_q == DEB_LAST) begin
                        key_valid_d = 1'b1;
                        key_code_d  = key_new;
                        word_d      = {word[11:0], key_new};
                        deb_d       = '0;
                        state_d     = HELD;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    dwell_d   = '0;
                    deb_d     = '0;
                end
            end

            HELD: begin
                // Release is accepted only after a full debounce window of all-high rows.
                if (rows_s == 4'b1111) begin
                    if (deb_q == DEB_LAST) begin
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                        dwell_d   = '0;
                        deb_d     = '0;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    deb_d = '0;
                end
            end

            default: begin
                state_d   = SCAN;
                col_idx_d = 2'd0;
                dwell_d   = '0;
                deb_d     = '0;
            end
        endcase

        if (clear) begin
            word_d = 16'h0000;
        end

        col_out_d = col_pattern(col_idx_d);
    end

endmodule
